// File: rtl/cpu_cmd_sequencer.sv
// Command sequencer feeding the CPU datapath: queues {cmd, operands} words, issues them one at a
// time paced by cpu_rdy, captures the CPU result and guards each command with a watchdog.
module cpu_cmd_sequencer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255,
    parameter logic [6:0]  NOP_CMD = 7'h00
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [6:0]               s_cmd,
    input  logic [4*WIDTH-1:0]       s_din,
    output logic [6:0]               cpu_cmd,
    output logic [WIDTH-1:0]         cpu_din1,
    output logic [WIDTH-1:0]         cpu_din2,
    output logic [WIDTH-1:0]         cpu_din3,
    output logic [WIDTH-1:0]         cpu_din4,
    input  logic                     cpu_rdy,
    input  logic [2*WIDTH-1:0]       cpu_result,
    input  logic                     cpu_zero,
    input  logic                     cpu_error,
    output logic                     r_valid,
    input  logic                     r_ready,
    output logic [2*WIDTH-1:0]       r_data,
    output logic [2:0]               r_flags,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     tout_seen
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned EW = 7 + 4*WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ABORT,
        ST_RESULT
    } state_t;

    state_t               state_q, state_d;
    logic [EW-1:0]        mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic [TW-1:0]        wdog_q, wdog_d;
    logic [6:0]           cmd_q, cmd_d;
    logic [4*WIDTH-1:0]   din_q, din_d;
    logic                 r_valid_q, r_valid_d;
    logic [2*WIDTH-1:0]   r_data_q, r_data_d;
    logic [2:0]           r_flags_q, r_flags_d;
    logic                 tout_q, tout_d;
    logic                 push, pop, wdog_expired;
    logic [EW-1:0]        head;

    // Acceptance looks only at the registered count, so a full FIFO refuses even in a pop cycle.
    assign s_ready      = (count_q != CW'(DEPTH));
    assign push         = s_valid && s_ready;
    assign head         = mem_q[rd_ptr_q];
    assign wdog_expired = (wdog_q == TW'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        cmd_d     = cmd_q;
        din_d     = din_q;
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_flags_d = r_flags_q;
        tout_d    = tout_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0 && cpu_rdy) begin
                    pop     = 1'b1;
                    cmd_d   = head[EW-1 -: 7];
                    din_d   = head[4*WIDTH-1:0];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Acceptance wins over a watchdog expiry in the same cycle.
                if (!cpu_rdy) begin
                    cmd_d   = NOP_CMD;
                    state_d = ST_WAIT;
                end else if (wdog_expired) begin
                    cmd_d   = NOP_CMD;
                    state_d = ST_ABORT;
                end
            end
            ST_WAIT: begin
                if (cpu_rdy) begin
                    r_data_d  = cpu_result;
                    r_flags_d = {1'b0, cpu_error, cpu_zero};
                    r_valid_d = 1'b1;
                    state_d   = ST_RESULT;
                end else if (wdog_expired) begin
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                cmd_d     = NOP_CMD;
                r_data_d  = '0;
                r_flags_d = 3'b100;
                r_valid_d = 1'b1;
                tout_d    = 1'b1;
                state_d   = ST_RESULT;
            end
            ST_RESULT: begin
                if (r_ready) begin
                    r_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wdog_d = '0;
        if (state_d == state_q && (state_q == ST_ISSUE || state_q == ST_WAIT)) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wdog_q    <= '0;
            cmd_q     <= NOP_CMD;
            din_q     <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_flags_q <= '0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wdog_q    <= wdog_d;
            cmd_q     <= cmd_d;
            din_q     <= din_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            r_flags_q <= r_flags_d;
            tout_q    <= tout_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {s_cmd, s_din};
    end

    assign cpu_cmd    = cmd_q;
    assign cpu_din1   = din_q[WIDTH-1:0];
    assign cpu_din2   = din_q[2*WIDTH-1:WIDTH];
    assign cpu_din3   = din_q[3*WIDTH-1:2*WIDTH];
    assign cpu_din4   = din_q[4*WIDTH-1:3*WIDTH];
    assign r_valid    = r_valid_q;
    assign r_data     = r_data_q;
    assign r_flags    = r_flags_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != ST_IDLE) || (count_q != '0);
    assign tout_seen  = tout_q;

endmodule

// File: tb/tb_cpu_cmd_sequencer.sv
// Randomized bench for cpu_cmd_sequencer: behavioural CPU stand-in plus an in-order scoreboard
// of expected results derived from each pushed word.
module tb_cpu_cmd_sequencer;

    localparam int unsigned W  = 8;
    localparam int          D  = 4;
    localparam int unsigned TO = 8;
    localparam logic [6:0]  NOP = 7'h00;
    localparam int M_NORMAL = 0;
    localparam int M_HANG   = 1;
    localparam int M_STALL  = 2;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid, s_ready;
    logic [6:0]  s_cmd;
    logic [31:0] s_din;
    logic [6:0]  cpu_cmd;
    logic [7:0]  cpu_din1, cpu_din2, cpu_din3, cpu_din4;
    logic        cpu_rdy;
    logic [15:0] cpu_result;
    logic        cpu_zero, cpu_error;
    logic        r_valid, r_ready;
    logic [15:0] r_data;
    logic [2:0]  r_flags;
    logic [2:0]  fifo_count;
    logic        busy, tout_seen;

    always #5 clk = ~clk;

    cpu_cmd_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO), .NOP_CMD(NOP)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_cmd(s_cmd), .s_din(s_din),
        .cpu_cmd(cpu_cmd), .cpu_din1(cpu_din1), .cpu_din2(cpu_din2),
        .cpu_din3(cpu_din3), .cpu_din4(cpu_din4), .cpu_rdy(cpu_rdy),
        .cpu_result(cpu_result), .cpu_zero(cpu_zero), .cpu_error(cpu_error),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_flags(r_flags),
        .fifo_count(fifo_count), .busy(busy), .tout_seen(tout_seen)
    );

    exp_t        exp_q[$];
    logic [38:0] to_send[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          mode = M_NORMAL, force_acc = -1, force_busy = -1, rr_mode = 0;
    bit          burst = 1'b0, push_now = 1'b0, hs_now = 1'b0, tout_exp = 1'b0;
    int          pushed = 0, issued = 0, handled = 0, cyc = 0;
    int          push_cyc = 0, issue_cyc = 0, hs_cyc = 0, rise_cyc = 0, max_cnt = 0;
    logic [6:0]  prev_cmd = NOP;
    logic        prev_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] cpu_calc(input logic [7:0] a, b, c, d);
        logic [15:0] aa, bb, cc, dd;
        aa = {8'd0, a}; bb = {8'd0, b}; cc = {8'd0, c}; dd = {8'd0, d};
        return aa * bb + cc * dd;
    endfunction

    // Result the consumer must see for a word: aborted commands carry only the timeout flag.
    function automatic exp_t ref_result(input logic [38:0] w, input int m);
        exp_t        e;
        logic [15:0] r;
        if (m != M_NORMAL) begin
            e.data  = '0;
            e.flags = 3'b100;
        end else begin
            r       = cpu_calc(w[7:0], w[15:8], w[23:16], w[31:24]);
            e.data  = r;
            e.flags = {1'b0, w[38], r == 16'd0};
        end
        return e;
    endfunction

    function automatic logic [38:0] rand_word();
        logic [7:0] d [4];
        for (int unsigned i = 0; i < 4; i++)
            d[i] = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
        return {7'($urandom_range(1, 127)), d[3], d[2], d[1], d[0]};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cpu_cmd"},    32'(cpu_cmd), 32'(NOP));
        check_eq({tag, "_cpu_din1"},   32'(cpu_din1), 32'd0);
        check_eq({tag, "_cpu_din2"},   32'(cpu_din2), 32'd0);
        check_eq({tag, "_cpu_din3"},   32'(cpu_din3), 32'd0);
        check_eq({tag, "_cpu_din4"},   32'(cpu_din4), 32'd0);
        check_eq({tag, "_r_valid"},    32'(r_valid), 32'd0);
        check_eq({tag, "_r_data"},     32'(r_data), 32'd0);
        check_eq({tag, "_r_flags"},    32'(r_flags), 32'd0);
        check_eq({tag, "_tout_seen"},  32'(tout_seen), 32'd0);
        check_eq({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
        check_eq({tag, "_busy"},       32'(busy), 32'd0);
        check_eq({tag, "_s_ready"},    32'(s_ready), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((to_send.size() != 0 || exp_q.size() != 0 || pushed != handled || push_now || hs_now)
               && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        check_eq({tag, "_drain_left"}, 32'(to_send.size() + exp_q.size()), 32'd0);
        check_eq({tag, "_inflight"}, 32'(pushed - handled), 32'd0);
        @(posedge clk); #2;
    endtask

    // Producer: presents queued words, records a push when s_valid meets the registered s_ready.
    initial begin
        s_valid = 1'b0; s_cmd = '0; s_din = '0;
        forever begin
            @(negedge clk);
            if (!reset || to_send.size() == 0) begin
                s_valid = 1'b0;
            end else begin
                s_valid = burst ? 1'b1 : ($urandom_range(0, 3) != 0);
                {s_cmd, s_din} = to_send[0];
                if (s_valid && s_ready) begin
                    push_now = 1'b1;
                    exp_q.push_back(ref_result(to_send[0], mode));
                    void'(to_send.pop_front());
                end
            end
        end
    end

    // Consumer: checks every presented result against the scoreboard head, drives r_ready.
    initial begin
        r_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                r_ready = 1'b0;
                continue;
            end
            if (r_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("r_valid_unexpected", 32'(r_valid), 32'd0);
                end else begin
                    check_eq("r_data", 32'(r_data), 32'(exp_q[0].data));
                    check_eq("r_flags", 32'(r_flags), 32'(exp_q[0].flags));
                    if (exp_q[0].flags[2]) tout_exp = 1'b1;
                end
            end
            check_eq("tout_seen", 32'(tout_seen), 32'(tout_exp));
            case (rr_mode)
                1:       r_ready = 1'b0;
                2:       r_ready = 1'b1;
                default: r_ready = 1'($urandom_range(0, 1));
            endcase
            if (r_valid && r_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                hs_now = 1'b1;
            end
        end
    end

    // Monitor: bookkeeping of pushes/issues/handshakes and occupancy checks after each edge.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                prev_cmd   = NOP;
                prev_valid = 1'b0;
                continue;
            end
            cyc++;
            if (push_now) begin pushed++; push_cyc = cyc; push_now = 1'b0; end
            if (hs_now)   begin handled++; hs_cyc = cyc; hs_now = 1'b0; end
            if (cpu_cmd != NOP && prev_cmd == NOP) begin issued++; issue_cyc = cyc; end
            if (r_valid && !prev_valid) rise_cyc = cyc;
            prev_cmd   = cpu_cmd;
            prev_valid = r_valid;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            check_eq("fifo_count", 32'(fifo_count), 32'(pushed - issued));
            check_eq("s_ready", 32'(s_ready), 32'((pushed - issued) < D));
            check_eq("busy", 32'(busy), 32'(pushed != handled));
        end
    end

    // CPU stand-in: accepts a command by dropping cpu_rdy, computes its result from the pins.
    initial begin
        logic [6:0]  lc;
        logic [31:0] ld;
        int unsigned acc, busyn;
        int          lmode;
        bit          rst_hit;
        cpu_rdy = 1'b1; cpu_result = '0; cpu_zero = 1'b0; cpu_error = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                cpu_rdy = 1'b1;
                continue;
            end
            if (cpu_rdy && cpu_cmd != NOP && mode != M_HANG) begin
                lc      = cpu_cmd;
                ld      = {cpu_din4, cpu_din3, cpu_din2, cpu_din1};
                lmode   = mode;
                acc     = (force_acc >= 0) ? int'(force_acc) : $urandom_range(0, 2);
                busyn   = (mode == M_STALL) ? TO + 4 :
                          (force_busy >= 0) ? int'(force_busy) : $urandom_range(1, 4);
                rst_hit = 1'b0;
                for (int unsigned i = 0; i < acc; i++) begin
                    @(posedge clk); #1;
                    if (!reset) begin rst_hit = 1'b1; break; end
                    check_eq("cmd_hold_issue", 32'(cpu_cmd), 32'(lc));
                    check_eq("din_hold_issue", {cpu_din4, cpu_din3, cpu_din2, cpu_din1}, ld);
                end
                if (!rst_hit) begin
                    cpu_rdy = 1'b0;
                    for (int unsigned i = 0; i < busyn; i++) begin
                        @(posedge clk); #1;
                        if (!reset) begin rst_hit = 1'b1; break; end
                        check_eq("cmd_nop_wait", 32'(cpu_cmd), 32'(NOP));
                        if (lmode == M_NORMAL)
                            check_eq("din_hold_wait", {cpu_din4, cpu_din3, cpu_din2, cpu_din1}, ld);
                    end
                end
                if (!rst_hit) begin
                    cpu_result = cpu_calc(ld[7:0], ld[15:8], ld[23:16], ld[31:24]);
                    cpu_zero   = (cpu_result == 16'd0);
                    cpu_error  = lc[6];
                end
                cpu_rdy = 1'b1;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "time budget exceeded");
    end

    initial begin
        int          n;
        int          ibase, hbase, h;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) reset = 1'b1;

        // Single command, CPU busy for 2 cycles, then the minimum-latency path with a zero/error result.
        rr_mode = 2; force_acc = 0; force_busy = 2;
        to_send.push_back({7'h05, 8'd0, 8'd0, 8'd4, 8'd3});
        drain("t1");
        check_eq("t1_latency", 32'(rise_cyc - push_cyc), 32'd4);
        force_busy = 1;
        to_send.push_back({7'h40, 32'd0});
        drain("t5");
        check_eq("t5_min_latency", 32'(rise_cyc - push_cyc), 32'd3);
        force_acc = -1; force_busy = -1;

        // Burst into a stalled result port: occupancy must top out at DEPTH.
        max_cnt = 0; burst = 1'b1; rr_mode = 1;
        repeat (6) to_send.push_back(rand_word());
        repeat (20) @(posedge clk);
        #2 check_eq("t2_max_count", 32'(max_cnt), 32'(D));
        burst = 1'b0; rr_mode = 0;
        drain("t2");

        // CPU never accepts: abort from ISSUE; then CPU never finishes: abort from WAIT.
        mode = M_HANG; rr_mode = 2;
        repeat (2) to_send.push_back(rand_word());
        drain("t3_hang");
        check_eq("t3_issue_timeout", 32'(rise_cyc - issue_cyc), 32'(TO + 1));
        mode = M_STALL; force_acc = 0;
        to_send.push_back(rand_word());
        drain("t3_stall");
        check_eq("t3_wait_timeout", 32'(rise_cyc - issue_cyc), 32'(TO + 2));
        mode = M_NORMAL; force_acc = -1;

        // Result held back: no further issue until the handshake, next issue one cycle after it.
        rr_mode = 1; ibase = issued; hbase = handled;
        repeat (2) to_send.push_back(rand_word());
        n = 0;
        while (!r_valid && n < 200) begin @(posedge clk); #2; n++; end
        repeat (10) @(posedge clk);
        #2 check_eq("t4_single_issue", 32'(issued - ibase), 32'd1);
        check_eq("t4_valid_held", 32'(r_valid), 32'd1);
        rr_mode = 2;
        n = 0;
        while (handled - hbase < 1 && n < 200) begin @(posedge clk); #2; n++; end
        h = hs_cyc;
        n = 0;
        while (issued - ibase < 2 && n < 200) begin @(posedge clk); #2; n++; end
        check_eq("t4_issue_after_hs", 32'(issue_cyc - h), 32'd1);
        drain("t4");

        // Random traffic.
        rr_mode = 0;
        repeat (30) to_send.push_back(rand_word());
        drain("rand");

        // Reset while a command sits in WAIT with three more queued.
        mode = M_STALL; force_acc = 0; burst = 1'b1; rr_mode = 1;
        repeat (4) to_send.push_back(rand_word());
        n = 0;
        while (!(to_send.size() == 0 && !push_now && cpu_rdy == 1'b0) && n < 100) begin
            @(posedge clk); #2; n++;
        end
        check_eq("t6_count_before_reset", 32'(fifo_count), 32'd3);
        @(posedge clk); #3;
        reset = 1'b0;
        #1 check_reset_outputs("t6");
        to_send.delete(); exp_q.delete();
        pushed = 0; issued = 0; handled = 0;
        push_now = 1'b0; hs_now = 1'b0; tout_exp = 1'b0;
        mode = M_NORMAL; force_acc = -1; burst = 1'b0; rr_mode = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) begin
            @(posedge clk); #2;
            check_eq("t6_idle_cmd", 32'(cpu_cmd), 32'(NOP));
            check_eq("t6_idle_busy", 32'(busy), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
